ps2_frame_ctrl: RTL and testbench
=================================

# ps2_frame_ctrl

Frame-level controller for the PS/2 keyboard link, sitting directly after the two-channel debouncer in the 25 MHz keyboard path. Detects falling edges on the debounced keyboard clock and samples the debounced data line in an 11-bit frame (start, 8 data LSB-first, odd parity, stop). Decodes the 0xE0 (extended) and 0xF0 (break) prefixes, then delivers one qualified scan code per key event with a one-cycle strobe. Framing faults produce a one-cycle error strobe.

## Interface
Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles without a kbd clock fall before an in-progress frame is abandoned (2 ms at 25 MHz). Only used with PS2_TIMEOUT_EN. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  25 MHz system clock
- rst  in  1  reset; asynchronous, active-high
- kbd_clk_db  in  1  debounced PS/2 clock
- kbd_data_db  in  1  debounced PS/2 data
- scan_code  out  8  last completed non-prefix byte
- is_break  out  1  scan_code came after an 0xF0 prefix
- is_extended  out  1  scan_code came after an 0xE0 prefix
- code_valid  out  1  one-cycle strobe: scan_code, is_break and is_extended were updated
- frame_err  out  1  one-cycle strobe: frame discarded
- busy  out  1  high while state != IDLE

## Operation
- Edge detect: clk_q <= kbd_clk_db. Reset value of clk_q is 1. fall = clk_q & ~kbd_clk_db. All sampling of kbd_data_db happens only in a cycle with fall=1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA and set bit_cnt=0. On fall with data=1 (bad start bit), pulse frame_err and stay in IDLE.
  - DATA: on each fall, shreg <= {data, shreg[7:1]} and bit_cnt increments. On the fall with bit_cnt=7, go to PARITY.
  - PARITY: on fall, capture par_bit and go to STOP.
  - STOP: on fall, the byte is good when data=1 and ^{shreg,par_bit}=1. Go to IDLE in both cases. A bad stop bit or bad parity pulses frame_err.
- Good byte handling:
  - 0xE0: set ext_flag. No strobe.
  - 0xF0: set brk_flag. No strobe.
  - Any other byte: scan_code <= byte, is_break <= brk_flag, is_extended <= ext_flag, pulse code_valid, then clear both flags.
  - Prefixes accumulate in any order.
- On any frame_err: clear both flags. scan_code, is_break and is_extended keep their previous values.
- All outputs are registered.
- Reset values: scan_code=0x00, is_break=0, is_extended=0, code_valid=0, frame_err=0, busy=0. Internal reset values: state=IDLE, bit_cnt=0, flags=0, timeout counter=0.
- Reset asserted mid-frame discards the partial frame immediately. After release, the next start bit is decoded normally.

## Timing
- fall is seen in cycle N, i.e. the first cycle in which kbd_clk_db=0 while clk_q=1. Any resulting state change, code_valid or frame_err appears in cycle N+1.
- code_valid and frame_err are exactly one cycle wide and are never asserted together.
- busy rises in cycle N+1 after the start-bit fall. It falls in cycle N+1 after the stop-bit fall or after a timeout.
- Frames arrive at most every ~1 ms, so no output buffering is needed. An unread code is overwritten by the next one.

## Configuration
- PS2_TIMEOUT_EN defined:
  - The counter is cleared on every fall and whenever state=IDLE. Otherwise it increments every cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 in a non-IDLE state: pulse frame_err, clear the flags and go to IDLE.
  - If a fall occurs in the same cycle as expiry, the fall wins: the counter clears and no error is raised.
- PS2_TIMEOUT_EN undefined: no counter is built. The FSM waits indefinitely for the next fall. frame_err comes only from start, parity or stop faults.

## Test plan
- Frame 0x1C, driven as start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1 -> scan_code=0x1C, code_valid high for 1 cycle, is_break=0, is_extended=0, busy low afterwards.
- Frames 0xF0 then 0x1C -> exactly one code_valid, with scan_code=0x1C and is_break=1. Following frame 0x1C -> is_break=0.
- Frames 0xE0, 0xF0, 0x75 -> one code_valid, with scan_code=0x75, is_extended=1 and is_break=1.
- Frame 0x1C with parity 1 -> frame_err 1 cycle, no code_valid, scan_code unchanged. Next frame 0x1C with stop bit 0 -> frame_err 1 cycle.
- With PS2_TIMEOUT_EN: start bit plus 3 data bits, then kbd_clk_db held high for TIMEOUT_CYCLES -> frame_err 1 cycle, busy=0. Next frame 0x29 -> scan_code=0x29, code_valid. Without the macro, the same stimulus leaves busy=1 with no frame_err.
- rst pulsed after 5 data bits of a frame -> all outputs 0 during reset. Next full frame 0x29 decodes correctly with no frame_err.

Source files
------------

// File: rtl/ps2_frame_ctrl.sv
// PS/2 keyboard frame controller: samples 11-bit frames on kbd clock falls, decodes E0/F0 prefixes.
// Optional frame timeout is built when PS2_TIMEOUT_EN is defined.
module ps2_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_clk_db,
  input  logic       kbd_data_db,
  output logic [7:0] scan_code,
  output logic       is_break,
  output logic       is_extended,
  output logic       code_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e     state_q;
  logic       clk_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shreg_q;
  logic       par_q;
  logic       ext_q;
  logic       brk_q;
  logic [7:0] scan_code_q;
  logic       is_break_q;
  logic       is_extended_q;
  logic       code_valid_q;
  logic       frame_err_q;
  logic       busy_q;

  logic fall;
  logic tmo_expire;

  assign fall = clk_q & ~kbd_clk_db;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q;

  // A fall in the expiry cycle wins over the timeout.
  assign tmo_expire = (state_q != StIdle) && !fall && (tmo_q == TmoLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (fall || state_q == StIdle) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_tmo_cfg;
  assign unused_tmo_cfg = TIMEOUT_CYCLES;
  assign tmo_expire     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      clk_q         <= 1'b1;
      bit_cnt_q     <= 3'd0;
      shreg_q       <= 8'h00;
      par_q         <= 1'b0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      scan_code_q   <= 8'h00;
      is_break_q    <= 1'b0;
      is_extended_q <= 1'b0;
      code_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      clk_q        <= kbd_clk_db;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fall) begin
            if (!kbd_data_db) begin
              state_q   <= StData;
              bit_cnt_q <= 3'd0;
              busy_q    <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end
          end
        end
        StData: begin
          if (fall) begin
            shreg_q   <= {kbd_data_db, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StParity;
            end
          end
        end
        StParity: begin
          if (fall) begin
            par_q   <= kbd_data_db;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (fall) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (kbd_data_db && (^{shreg_q, par_q})) begin
              if (shreg_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else if (shreg_q == 8'hF0) begin
                brk_q <= 1'b1;
              end else begin
                scan_code_q   <= shreg_q;
                is_break_q    <= brk_q;
                is_extended_q <= ext_q;
                code_valid_q  <= 1'b1;
                ext_q         <= 1'b0;
                brk_q         <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (tmo_expire) begin
        state_q     <= StIdle;
        busy_q      <= 1'b0;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end
    end
  end

  assign scan_code   = scan_code_q;
  assign is_break    = is_break_q;
  assign is_extended = is_extended_q;
  assign code_valid  = code_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// Scoreboard bench for ps2_frame_ctrl: frame-level reference model feeds an expected-event queue.
module tb_ps2_frame_ctrl;

  localparam int unsigned Tmo = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       kbd_clk;
  logic       kbd_data;
  logic [7:0] scan_code;
  logic       is_break;
  logic       is_extended;
  logic       code_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  ps2_frame_ctrl #(
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kbd_clk_db (kbd_clk),
    .kbd_data_db(kbd_data),
    .scan_code  (scan_code),
    .is_break   (is_break),
    .is_extended(is_extended),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  ev_t        exp_q[$];
  logic       m_brk, m_ext;
  logic [7:0] m_code;
  logic       m_code_brk, m_code_ext;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per frame, applied before the frame's final fall.
  task automatic model_err();
    exp_q.push_back('{err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0});
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      exp_q.push_back('{err: 1'b0, code: b, brk: m_brk, ext: m_ext});
      m_code     = b;
      m_code_brk = m_brk;
      m_code_ext = m_ext;
      m_brk      = 1'b0;
      m_ext      = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_brk      = 1'b0;
    m_ext      = 1'b0;
    m_code     = 8'h00;
    m_code_brk = 1'b0;
    m_code_ext = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 kbd_data = b;
    repeat (3) @(posedge clk);
    #1 kbd_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1 kbd_clk = 1'b1;
  endtask

  task automatic check_held();
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("scan_code_held", scan_code, m_code);
    check("is_break_held", is_break, m_code_brk);
    check("is_ext_held", is_extended, m_code_ext);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    logic par;
    par = ~(^b) ^ par_flip;
    ps2_bit(1'b0);
    @(negedge clk);
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    if (par_flip || !stop) model_err();
    else model_byte(b);
    ps2_bit(stop);
    repeat (3) @(posedge clk);
    check_held();
  endtask

  task automatic bad_start();
    model_err();
    ps2_bit(1'b1);
    repeat (3) @(posedge clk);
    check_held();
  endtask

  // Monitor: pops one expected event per strobe cycle.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (code_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: code_valid=%0b frame_err=%0b with empty queue at %0t",
                 code_valid, frame_err, $time);
      end else begin
        e = exp_q.pop_front();
        check("strobe_err", frame_err, e.err);
        check("strobe_valid", code_valid, !e.err);
        if (!e.err) begin
          check("scan_code", scan_code, e.code);
          check("is_break", is_break, e.brk);
          check("is_extended", is_extended, e.ext);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    kbd_clk  = 1'b1;
    kbd_data = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_scan_code", scan_code, 0);
    check("rst_flags", {is_break, is_extended, code_valid, frame_err, busy}, 0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1);
    bad_start();
    send_frame(8'h33, 1'b0, 1'b1);

    // Abandoned frame: start plus 3 data bits, then the clock stays high.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
`ifdef PS2_TIMEOUT_EN
    model_err();
`endif
    ps2_bit(1'b1);
    repeat (Tmo + 10) @(posedge clk);
    @(negedge clk);
`ifdef PS2_TIMEOUT_EN
    check("tmo_busy", busy, 0);
`else
    check("no_tmo_busy", busy, 1);
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
`endif
    send_frame(8'h29, 1'b0, 1'b1);

    // Reset in the middle of a frame.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_scan_code", scan_code, 0);
    check("midrst_flags", {is_break, is_extended, code_valid, frame_err, busy}, 0);
    @(posedge clk); #1 rst = 1'b0;
    send_frame(8'h29, 1'b0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0: bad_start();
        1: send_frame(8'($urandom), 1'b1, 1'b1);
        2: send_frame(8'($urandom), 1'b0, 1'b0);
        3: send_frame(8'hE0, 1'b0, 1'b1);
        4: send_frame(8'hF0, 1'b0, 1'b1);
        default: send_frame(8'($urandom), 1'b0, 1'b1);
      endcase
    end

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
